rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_if.sv | 32 +++
 rtl/rf_wb_arbiter.sv | 59 +++++
 tb/tb_rf_wb_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rf_wb_if.sv
// rf_wb_if: pipeline writeback, long-latency result, decode hazard and register-file write signals
interface rf_wb_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd_dec;
  logic        rd_dec_wr;
  logic        stall;
  logic        wb_stall;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [31:0] WData;
  logic        sb_err;
  modport master (
    output wb_valid, wb_rd, wb_data, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
           rs1, rs2, rd_dec, rd_dec_wr,
    input  lu_ready, stall, wb_stall, RegWrite, RD, WData, sb_err
  );
  modport slave (
    input  wb_valid, wb_rd, wb_data, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
           rs1, rs2, rd_dec, rd_dec_wr,
    output lu_ready, stall, wb_stall, RegWrite, RD, WData, sb_err
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares one register-file write port between the pipeline and a buffered long-latency result
module rf_wb_arbiter #(
  parameter int HOLD_MAX = 3
) (
  input logic    clk,
  input logic    rst,
  rf_wb_if.slave bus
);
  localparam logic [3:0] HM = 4'(HOLD_MAX);
  logic        hb_valid_q, hb_valid_d;
  logic [4:0]  hb_rd_q, hb_rd_d;
  logic [31:0] hb_data_q, hb_data_d;
  logic [3:0]  age_q, age_d;
  logic [31:0] sb_q, sb_d;
  logic        sb_err_q, sb_err_d;
  logic        buf_gnt, pipe_gnt, wr_buf, cap;
  logic [31:0] clr, set, live;
  always_comb begin
    buf_gnt    = hb_valid_q && (!bus.wb_valid || bus.wb_rd == '0 || age_q == HM);
    pipe_gnt   = !buf_gnt && bus.wb_valid && bus.wb_rd != '0;
    wr_buf     = buf_gnt && hb_rd_q != '0;
    cap        = bus.lu_valid && !hb_valid_q;
    clr        = buf_gnt ? 32'(1) << hb_rd_q : '0;
    set        = (bus.lu_issue && bus.lu_issue_rd != '0) ? 32'(1) << bus.lu_issue_rd : '0;
    // bits being retired this cycle are forwarded, so they no longer block decode
    live       = sb_q & ~clr;
    hb_valid_d = cap ? 1'b1 : buf_gnt ? 1'b0 : hb_valid_q;
    hb_rd_d    = cap ? bus.lu_rd : hb_rd_q;
    hb_data_d  = cap ? bus.lu_data : hb_data_q;
    age_d      = (!hb_valid_q || buf_gnt) ? 4'd0 : (age_q == HM ? age_q : age_q + 4'd1);
    sb_d       = (live | set) & ~32'h1;
    sb_err_d   = sb_err_q || (bus.lu_valid && hb_valid_q) ||
                 (bus.lu_issue && bus.lu_issue_rd != '0 && live[bus.lu_issue_rd]);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      hb_valid_q <= 1'b0;
      hb_rd_q    <= '0;
      hb_data_q  <= '0;
      age_q      <= '0;
      sb_q       <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      hb_valid_q <= hb_valid_d;
      hb_rd_q    <= hb_rd_d;
      hb_data_q  <= hb_data_d;
      age_q      <= age_d;
      sb_q       <= sb_d;
      sb_err_q   <= sb_err_d;
    end
  end
  assign bus.lu_ready = !hb_valid_q;
  assign bus.wb_stall = bus.wb_valid && bus.wb_rd != '0 && buf_gnt;
  assign bus.RegWrite = wr_buf || pipe_gnt;
  assign bus.RD       = wr_buf ? hb_rd_q : pipe_gnt ? bus.wb_rd : '0;
  assign bus.WData    = wr_buf ? hb_data_q : pipe_gnt ? bus.wb_data : '0;
  assign bus.stall    = live[bus.rs1] || live[bus.rs2] || (bus.rd_dec_wr && live[bus.rd_dec]);
  assign bus.sb_err   = sb_err_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus random traffic checked against a queue-based reference model
module tb_rf_wb_arbiter;
  localparam int HM = 3;
  typedef struct {logic [4:0] rd; logic [31:0] d;} ent_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  rf_wb_if bus();
  rf_wb_arbiter #(.HOLD_MAX(HM)) dut (.clk(clk), .rst(rst), .bus(bus));
  int   checks = 0;
  int   errors = 0;
  ent_t hbq[$];
  int   waited = 0;
  bit   pend[32];
  bit   merr = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    rst = 1'b1;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.lu_issue = 0; bus.lu_issue_rd = 0;
    bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_data = 0;
    bus.rs1 = 0; bus.rs2 = 0; bus.rd_dec = 0; bus.rd_dec_wr = 0;
  endtask
  function automatic bit busy(input logic [4:0] r, input bit bg, input logic [4:0] hrd);
    return r != 0 && pend[r] && !(bg && hrd == r);
  endfunction
  // inputs are driven just after a negedge; compare mid-cycle, then advance the model past the posedge
  task automatic cyc();
    bit has, bg, pg, we;
    logic [4:0] hrd, erd;
    logic [31:0] hd, ed;
    #1;
    has = hbq.size() != 0;
    hrd = has ? hbq[0].rd : 5'd0;
    hd  = has ? hbq[0].d : 32'd0;
    bg  = has && (!bus.wb_valid || bus.wb_rd == 0 || waited >= HM);
    pg  = !bg && bus.wb_valid && bus.wb_rd != 0;
    we  = (bg && hrd != 0) || pg;
    erd = !we ? 5'd0 : (bg ? hrd : bus.wb_rd);
    ed  = !we ? 32'd0 : (bg ? hd : bus.wb_data);
    chk("lu_ready", 32'(bus.lu_ready), 32'(!has));
    chk("wb_stall", 32'(bus.wb_stall), 32'(bus.wb_valid && bus.wb_rd != 0 && bg));
    chk("RegWrite", 32'(bus.RegWrite), 32'(we));
    chk("RD", 32'(bus.RD), 32'(erd));
    chk("WData", bus.WData, ed);
    chk("stall", 32'(bus.stall), 32'(busy(bus.rs1, bg, hrd) || busy(bus.rs2, bg, hrd) ||
                                     (bus.rd_dec_wr && busy(bus.rd_dec, bg, hrd))));
    chk("sb_err", 32'(bus.sb_err), 32'(merr));
    if (!rst) begin
      hbq.delete();
      waited = 0;
      merr = 0;
      foreach (pend[i]) pend[i] = 0;
    end else begin
      if (bus.lu_valid && has) merr = 1;
      if (bus.lu_issue && bus.lu_issue_rd != 0 && busy(bus.lu_issue_rd, bg, hrd)) merr = 1;
      if (bg) begin
        pend[hrd] = 0;
        void'(hbq.pop_front());
        waited = 0;
      end else if (has) waited++;
      if (bus.lu_issue && bus.lu_issue_rd != 0) pend[bus.lu_issue_rd] = 1;
      if (bus.lu_valid && !has) begin
        hbq.push_back('{bus.lu_rd, bus.lu_data});
        waited = 0;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    idle();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    idle(); rst = 1'b0; cyc();
    idle(); cyc();
    // issue r5, consume from decode, then retire via buffer
    idle(); bus.lu_issue = 1; bus.lu_issue_rd = 5; cyc();
    idle(); bus.rs1 = 5; #1 chk("r5_stall", 32'(bus.stall), 1); cyc();
    idle(); bus.rs1 = 5; bus.lu_valid = 1; bus.lu_rd = 5; bus.lu_data = 32'hAA; cyc();
    idle(); bus.rs1 = 5; #1 chk("r5_rd", 32'(bus.RD), 5); chk("r5_data", bus.WData, 32'hAA); cyc();
    idle(); bus.rs1 = 5; #1 chk("r5_clear", 32'(bus.stall), 0); cyc();
    // aging: pipeline keeps the port for HOLD_MAX cycles
    idle(); bus.lu_valid = 1; bus.lu_rd = 7; bus.lu_data = 32'h77; cyc();
    for (int i = 0; i < HM; i++) begin
      idle(); bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'h33;
      #1 chk("age_pipe_rd", 32'(bus.RD), 3); cyc();
    end
    idle(); bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'h33;
    #1 chk("age_buf_rd", 32'(bus.RD), 7); chk("age_buf_stall", 32'(bus.wb_stall), 1); cyc();
    idle(); bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'h33;
    #1 chk("age_after_rd", 32'(bus.RD), 3); chk("age_after_stall", 32'(bus.wb_stall), 0); cyc();
    // pipeline writes to r0
    idle(); bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_data = 32'h99; cyc();
    idle(); bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'h55;
    #1 chk("r0_buf_rd", 32'(bus.RD), 9); chk("r0_buf_stall", 32'(bus.wb_stall), 0); cyc();
    idle(); bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'h55;
    #1 chk("r0_alone_we", 32'(bus.RegWrite), 0); cyc();
    // overflow into a full buffer
    idle(); bus.lu_valid = 1; bus.lu_rd = 10; bus.lu_data = 32'h10; bus.wb_valid = 1; bus.wb_rd = 2; cyc();
    idle(); bus.lu_valid = 1; bus.lu_rd = 11; bus.lu_data = 32'h11; bus.wb_valid = 1; bus.wb_rd = 2;
    #1 chk("ovf_ready", 32'(bus.lu_ready), 0); cyc();
    idle(); #1 chk("ovf_err", 32'(bus.sb_err), 1); chk("ovf_rd", 32'(bus.RD), 10); cyc();
    idle(); cyc();
    idle(); #1 chk("ovf_sticky", 32'(bus.sb_err), 1); rst = 1'b0; cyc();
    idle(); #1 chk("ovf_reset", 32'(bus.sb_err), 0); cyc();
    // retire and reissue the same register in one cycle
    idle(); bus.lu_issue = 1; bus.lu_issue_rd = 4; cyc();
    idle(); bus.lu_valid = 1; bus.lu_rd = 4; bus.lu_data = 32'h44; cyc();
    idle(); bus.lu_issue = 1; bus.lu_issue_rd = 4; bus.rs2 = 4;
    #1 chk("same_stall", 32'(bus.stall), 0); cyc();
    idle(); bus.rs2 = 4; #1 chk("same_set", 32'(bus.stall), 1); chk("same_err", 32'(bus.sb_err), 0); cyc();
    // reset mid-operation
    idle(); bus.lu_issue = 1; bus.lu_issue_rd = 5; cyc();
    idle(); bus.lu_valid = 1; bus.lu_rd = 4; bus.lu_data = 32'h4; bus.wb_valid = 1; bus.wb_rd = 1; cyc();
    idle(); bus.wb_valid = 1; bus.wb_rd = 1; bus.lu_issue = 1; bus.lu_issue_rd = 6; rst = 1'b0; cyc();
    idle(); bus.rs1 = 4; bus.rs2 = 5; bus.rd_dec = 6; bus.rd_dec_wr = 1;
    #1 chk("rst_stall", 32'(bus.stall), 0); chk("rst_ready", 32'(bus.lu_ready), 1);
    chk("rst_we", 32'(bus.RegWrite), 0); cyc();
    for (int i = 0; i < 600; i++) begin
      idle();
      rst = $urandom_range(0, 49) != 0;
      bus.wb_valid = $urandom_range(0, 2) != 0;
      bus.wb_rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
      bus.wb_data = $urandom;
      bus.lu_issue = $urandom_range(0, 4) == 0;
      bus.lu_issue_rd = 5'($urandom_range(0, 7));
      bus.lu_valid = $urandom_range(0, 3) == 0;
      bus.lu_rd = 5'($urandom_range(0, 7));
      bus.lu_data = $urandom;
      bus.rs1 = 5'($urandom_range(0, 7));
      bus.rs2 = 5'($urandom_range(0, 7));
      bus.rd_dec = 5'($urandom_range(0, 7));
      bus.rd_dec_wr = 1'($urandom_range(0, 1));
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
